// File: rtl/axi_ram_arbiter.sv
// Two-path AXI arbiter: NUM_MASTERS upstream masters share one axi_ram slave port.
// Latency: one grant-register cycle before AW/AR is routed; beats are routed combinationally.
// Backpressure: non-granted masters see READY=0; the granted master sees slave READY/VALID.
package axi_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 8;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } axi_ax_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
    } axi_w_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } axi_b_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        axi_w_t  w;
        axi_ax_t ar;
    } axi_mosi_data_t;

    typedef struct packed {
        axi_b_t b;
        axi_r_t r;
    } axi_miso_data_t;

    typedef struct packed {
        axi_mosi_data_t data;
        logic           aw_valid;
        logic           w_valid;
        logic           b_ready;
        logic           ar_valid;
        logic           r_ready;
    } axi_mosi_t;

    typedef struct packed {
        axi_miso_data_t data;
        logic           aw_ready;
        logic           w_ready;
        logic           b_valid;
        logic           ar_ready;
        logic           r_valid;
    } axi_miso_t;
endpackage

module axi_ram_arbiter
    import axi_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int GRANT_W     = $clog2(NUM_MASTERS)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  axi_mosi_t          s_mosi_i [NUM_MASTERS],
    output axi_miso_t          s_miso_o [NUM_MASTERS],
    output axi_mosi_t          m_mosi_o,
    input  axi_miso_t          m_miso_i,
    output logic [GRANT_W-1:0] wr_grant_o,
    output logic [GRANT_W-1:0] rd_grant_o,
    output logic               wr_busy_o,
    output logic               rd_busy_o
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    wr_state_t          wr_state, wr_state_nxt;
    rd_state_t          rd_state, rd_state_nxt;
    logic [GRANT_W-1:0] wr_grant, wr_grant_nxt, wr_ptr, wr_ptr_nxt;
    logic [GRANT_W-1:0] rd_grant, rd_grant_nxt, rd_ptr, rd_ptr_nxt;
    logic [NUM_MASTERS-1:0] aw_req, ar_req;

    // First requester at or above ptr, wrapping past NUM_MASTERS-1.
    function automatic logic [GRANT_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                   input logic [GRANT_W-1:0] ptr);
        logic [GRANT_W:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = {1'b0, ptr} + (GRANT_W+1)'(i);
            if (idx >= (GRANT_W+1)'(NUM_MASTERS))
                idx = idx - (GRANT_W+1)'(NUM_MASTERS);
            if (!found && req[idx[GRANT_W-1:0]]) begin
                found   = 1'b1;
                rr_pick = idx[GRANT_W-1:0];
            end
        end
    endfunction

    function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] g);
        rr_next = (g == GRANT_W'(NUM_MASTERS-1)) ? '0 : g + 1'b1;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_MASTERS; k++) begin
            aw_req[k] = s_mosi_i[k].aw_valid;
            ar_req[k] = s_mosi_i[k].ar_valid;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_state <= W_IDLE;
            wr_grant <= '0;
            wr_ptr   <= '0;
            rd_state <= R_IDLE;
            rd_grant <= '0;
            rd_ptr   <= '0;
        end else begin
            wr_state <= wr_state_nxt;
            wr_grant <= wr_grant_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_state <= rd_state_nxt;
            rd_grant <= rd_grant_nxt;
            rd_ptr   <= rd_ptr_nxt;
        end
    end

    // A granted master that drops AWVALID simply stalls the path; no re-arbitration.
    always_comb begin
        wr_state_nxt = wr_state;
        wr_grant_nxt = wr_grant;
        wr_ptr_nxt   = wr_ptr;
        case (wr_state)
            W_IDLE: if (|aw_req) begin
                wr_grant_nxt = rr_pick(aw_req, wr_ptr);
                wr_state_nxt = W_ADDR;
            end
            W_ADDR: if (s_mosi_i[wr_grant].aw_valid && m_miso_i.aw_ready)
                wr_state_nxt = W_DATA;
            W_DATA: if (s_mosi_i[wr_grant].w_valid && m_miso_i.w_ready &&
                        s_mosi_i[wr_grant].data.w.last)
                wr_state_nxt = W_RESP;
            W_RESP: if (m_miso_i.b_valid && s_mosi_i[wr_grant].b_ready) begin
                wr_ptr_nxt   = rr_next(wr_grant);
                wr_state_nxt = W_IDLE;
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_nxt = rd_state;
        rd_grant_nxt = rd_grant;
        rd_ptr_nxt   = rd_ptr;
        case (rd_state)
            R_IDLE: if (|ar_req) begin
                rd_grant_nxt = rr_pick(ar_req, rd_ptr);
                rd_state_nxt = R_ADDR;
            end
            R_ADDR: if (s_mosi_i[rd_grant].ar_valid && m_miso_i.ar_ready)
                rd_state_nxt = R_DATA;
            R_DATA: if (m_miso_i.r_valid && s_mosi_i[rd_grant].r_ready &&
                        m_miso_i.data.r.last) begin
                rd_ptr_nxt   = rr_next(rd_grant);
                rd_state_nxt = R_IDLE;
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Response payloads are broadcast; only handshake signals are steered to the owner.
    always_comb begin
        m_mosi_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            s_miso_o[k]      = '0;
            s_miso_o[k].data = m_miso_i.data;
        end
        case (wr_state)
            W_ADDR: begin
                m_mosi_o.data.aw             = s_mosi_i[wr_grant].data.aw;
                m_mosi_o.aw_valid            = s_mosi_i[wr_grant].aw_valid;
                s_miso_o[wr_grant].aw_ready  = m_miso_i.aw_ready;
            end
            W_DATA: begin
                m_mosi_o.data.w              = s_mosi_i[wr_grant].data.w;
                m_mosi_o.w_valid             = s_mosi_i[wr_grant].w_valid;
                s_miso_o[wr_grant].w_ready   = m_miso_i.w_ready;
            end
            W_RESP: begin
                m_mosi_o.b_ready             = s_mosi_i[wr_grant].b_ready;
                s_miso_o[wr_grant].b_valid   = m_miso_i.b_valid;
            end
            default: ;
        endcase
        case (rd_state)
            R_ADDR: begin
                m_mosi_o.data.ar             = s_mosi_i[rd_grant].data.ar;
                m_mosi_o.ar_valid            = s_mosi_i[rd_grant].ar_valid;
                s_miso_o[rd_grant].ar_ready  = m_miso_i.ar_ready;
            end
            R_DATA: begin
                m_mosi_o.r_ready             = s_mosi_i[rd_grant].r_ready;
                s_miso_o[rd_grant].r_valid   = m_miso_i.r_valid;
            end
            default: ;
        endcase
    end

    assign wr_grant_o = wr_grant;
    assign rd_grant_o = rd_grant;
    assign wr_busy_o  = (wr_state != W_IDLE);
    assign rd_busy_o  = (rd_state != R_IDLE);

endmodule

// File: tb/tb_axi_ram_arbiter.sv
// Directed bench for axi_ram_arbiter with two master BFMs and a small word-RAM slave model.
module tb_axi_ram_arbiter;
    import axi_pkg::*;

    localparam int BOUND = 100;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    axi_mosi_t s_mosi [2];
    axi_miso_t s_miso [2];
    axi_mosi_t m_mosi;
    axi_miso_t m_miso;
    logic      wr_grant, rd_grant, wr_busy, rd_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    axi_ram_arbiter #(.NUM_MASTERS(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_mosi_i(s_mosi), .s_miso_o(s_miso),
        .m_mosi_o(m_mosi), .m_miso_i(m_miso),
        .wr_grant_o(wr_grant), .rd_grant_o(rd_grant),
        .wr_busy_o(wr_busy), .rd_busy_o(rd_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: one word per 4-byte address, preloaded with 0xA000_0000 + index on reset.
    logic [31:0] mem [0:63];
    logic        s_wact, s_bpend, s_ract;
    logic [5:0]  s_wptr, s_rptr;
    logic [7:0]  s_wid, s_rid, s_rlen, s_rbeat;

    always_comb begin
        m_miso             = '0;
        m_miso.aw_ready    = !s_wact && !s_bpend;
        m_miso.w_ready     = s_wact;
        m_miso.b_valid     = s_bpend;
        m_miso.data.b.id   = s_wid;
        m_miso.ar_ready    = !s_ract;
        m_miso.r_valid     = s_ract;
        m_miso.data.r.id   = s_rid;
        m_miso.data.r.data = mem[s_rptr];
        m_miso.data.r.last = (s_rbeat == s_rlen);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
            s_wact <= 0; s_bpend <= 0; s_ract <= 0;
            s_wptr <= 0; s_rptr <= 0; s_wid <= 0; s_rid <= 0; s_rlen <= 0; s_rbeat <= 0;
        end else begin
            if (m_mosi.aw_valid && m_miso.aw_ready) begin
                s_wact <= 1; s_wptr <= m_mosi.data.aw.addr[7:2]; s_wid <= m_mosi.data.aw.id;
            end
            if (m_mosi.w_valid && m_miso.w_ready) begin
                for (int i = 0; i < 4; i++)
                    if (m_mosi.data.w.strb[i]) mem[s_wptr][8*i +: 8] <= m_mosi.data.w.data[8*i +: 8];
                s_wptr <= s_wptr + 1;
                if (m_mosi.data.w.last) begin s_wact <= 0; s_bpend <= 1; end
            end
            if (m_miso.b_valid && m_mosi.b_ready) s_bpend <= 0;
            if (m_mosi.ar_valid && m_miso.ar_ready) begin
                s_ract <= 1; s_rptr <= m_mosi.data.ar.addr[7:2]; s_rid <= m_mosi.data.ar.id;
                s_rlen <= m_mosi.data.ar.len; s_rbeat <= 0;
            end
            if (m_miso.r_valid && m_mosi.r_ready) begin
                s_rptr <= s_rptr + 1; s_rbeat <= s_rbeat + 1;
                if (m_miso.data.r.last) s_ract <= 0;
            end
        end
    end

    int  grant_log [$];
    bit  conc_phase = 0;
    int  overlap = 0, leak_b1 = 0, leak_r0 = 0;
    always @(negedge clk) begin
        if (m_mosi.aw_valid && m_miso.aw_ready) grant_log.push_back(int'(wr_grant));
        if (conc_phase) begin
            if (wr_busy && rd_busy) overlap++;
            if (s_miso[1].b_valid)  leak_b1++;
            if (s_miso[0].r_valid)  leak_r0++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic any_vr();
        logic v;
        v = m_mosi.aw_valid | m_mosi.w_valid | m_mosi.b_ready | m_mosi.ar_valid | m_mosi.r_ready;
        for (int k = 0; k < 2; k++)
            v = v | s_miso[k].aw_ready | s_miso[k].w_ready | s_miso[k].b_valid |
                s_miso[k].ar_ready | s_miso[k].r_valid;
        return v;
    endfunction

    logic [31:0] wr_dat [2][8];
    logic [31:0] rdat   [2][8];
    int          aw_c [2], b_c [2];
    logic [1:0]  bresp [2];
    logic [7:0]  bid [2], rid [2];
    bit          w_early [2];

    task automatic wr_burst(input int m, input logic [31:0] addr, input logic [7:0] len,
                            input logic [7:0] id, input logic [3:0] strb_last, input bit early);
        int n;
        w_early[m] = 0;
        if (early) begin
            s_mosi[m].data.w.data = wr_dat[m][0];
            s_mosi[m].data.w.strb = (len == 0) ? strb_last : 4'hF;
            s_mosi[m].data.w.last = (len == 0);
            s_mosi[m].w_valid     = 1;
            repeat (2) begin
                @(negedge clk); if (s_miso[m].w_ready) w_early[m] = 1;
                @(posedge clk); #1;
            end
        end
        s_mosi[m].data.aw = '{id: id, addr: addr, len: len, size: 3'd2, burst: 2'd1};
        s_mosi[m].aw_valid = 1;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (s_miso[m].w_ready) w_early[m] = 1;
        end while (!s_miso[m].aw_ready && n < BOUND);
        chk("aw_wait_in_bound", 32'(n < BOUND), 1);
        aw_c[m] = cyc;
        @(posedge clk); #1;
        s_mosi[m].aw_valid = 0;
        for (int bt = 0; bt <= int'(len); bt++) begin
            s_mosi[m].data.w.data = wr_dat[m][bt];
            s_mosi[m].data.w.strb = (bt == int'(len)) ? strb_last : 4'hF;
            s_mosi[m].data.w.last = (bt == int'(len));
            s_mosi[m].w_valid     = 1;
            n = 0;
            do begin @(negedge clk); n++; end while (!s_miso[m].w_ready && n < BOUND);
            chk("w_wait_in_bound", 32'(n < BOUND), 1);
            @(posedge clk); #1;
        end
        s_mosi[m].w_valid = 0;
        s_mosi[m].b_ready = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_miso[m].b_valid && n < BOUND);
        chk("b_wait_in_bound", 32'(n < BOUND), 1);
        bresp[m] = s_miso[m].data.b.resp;
        bid[m]   = s_miso[m].data.b.id;
        b_c[m]   = cyc;
        @(posedge clk); #1;
        s_mosi[m].b_ready = 0;
    endtask

    task automatic rd_burst(input int m, input logic [31:0] addr, input logic [7:0] len,
                            input logic [7:0] id);
        int n;
        s_mosi[m].data.ar = '{id: id, addr: addr, len: len, size: 3'd2, burst: 2'd1};
        s_mosi[m].ar_valid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_miso[m].ar_ready && n < BOUND);
        chk("ar_wait_in_bound", 32'(n < BOUND), 1);
        @(posedge clk); #1;
        s_mosi[m].ar_valid = 0;
        s_mosi[m].r_ready  = 1;
        for (int bt = 0; bt <= int'(len); bt++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!s_miso[m].r_valid && n < BOUND);
            chk("r_wait_in_bound", 32'(n < BOUND), 1);
            rdat[m][bt] = s_miso[m].data.r.data;
            rid[m]      = s_miso[m].data.r.id;
            @(posedge clk); #1;
        end
        s_mosi[m].r_ready = 0;
    endtask

    task automatic reset_pulse();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        int n;
        s_mosi[0] = '0;
        s_mosi[1] = '0;
        #1;
        // Reset state
        chk("reset_any_valid_ready", 32'(any_vr()), 0);
        chk("reset_wr_busy", 32'(wr_busy), 0);
        chk("reset_rd_busy", 32'(rd_busy), 0);
        chk("reset_wr_grant", 32'(wr_grant), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Single write then read from master 0 (word 2 preload A0000002, strobe 9)
        wr_dat[0][0] = 32'h0123_4567; wr_dat[0][1] = 32'h89AB_CDEF; wr_dat[0][2] = 32'hFFFF_FFFF;
        wr_burst(0, 32'h1, 8'd2, 8'h05, 4'h9, 0);
        chk("t1_bresp", 32'(bresp[0]), 0);
        chk("t1_bid", 32'(bid[0]), 32'h05);
        chk("t1_wr_busy_after_b", 32'(wr_busy), 0);
        rd_burst(0, 32'h1, 8'd2, 8'h06);
        chk("t1_rd_beat0", rdat[0][0], 32'h0123_4567);
        chk("t1_rd_beat1", rdat[0][1], 32'h89AB_CDEF);
        chk("t1_rd_beat2_masked", rdat[0][2] & 32'hFF00_00FF, 32'hFF00_00FF);
        chk("t1_rid", 32'(rid[0]), 32'h06);

        // Simultaneous AW from masters 0 and 1, fresh round-robin pointers
        reset_pulse();
        grant_log.delete();
        wr_dat[0][0] = 32'h0000_AAAA; wr_dat[1][0] = 32'h0000_BBBB;
        fork
            wr_burst(0, 32'h40, 8'd0, 8'h10, 4'hF, 0);
            wr_burst(1, 32'h44, 8'd0, 8'h11, 4'hF, 0);
        join
        chk("t2_grant_count", 32'(grant_log.size()), 2);
        chk("t2_grant_first", 32'(grant_log[0]), 0);
        chk("t2_grant_second", 32'(grant_log[1]), 1);
        chk("t2_m1_aw_after_m0_b", 32'(aw_c[1] > b_c[0]), 1);
        chk("t2_m1_bid", 32'(bid[1]), 32'h11);

        // Fairness: master 0 back-to-back x3 against one pending write from master 1
        grant_log.delete();
        fork
            repeat (3) wr_burst(0, 32'h48, 8'd0, 8'h20, 4'hF, 0);
            wr_burst(1, 32'h4C, 8'd0, 8'h21, 4'hF, 0);
        join
        chk("t3_grant_count", 32'(grant_log.size()), 4);
        chk("t3_grant_0", 32'(grant_log[0]), 0);
        chk("t3_grant_1", 32'(grant_log[1]), 1);
        chk("t3_grant_2", 32'(grant_log[2]), 0);
        chk("t3_grant_3", 32'(grant_log[3]), 0);

        // Concurrent write (m0, 0x10) and read (m1, 0x20)
        wr_dat[0][0] = 32'h1111_1111; wr_dat[0][1] = 32'h2222_2222;
        wr_dat[0][2] = 32'h3333_3333; wr_dat[0][3] = 32'h4444_4444;
        conc_phase = 1;
        fork
            wr_burst(0, 32'h10, 8'd3, 8'h30, 4'hF, 0);
            rd_burst(1, 32'h20, 8'd3, 8'h31);
        join
        conc_phase = 0;
        chk("t4_paths_overlap", 32'(overlap > 0), 1);
        chk("t4_no_bvalid_to_m1", 32'(leak_b1), 0);
        chk("t4_no_rvalid_to_m0", 32'(leak_r0), 0);
        chk("t4_rd_beat0", rdat[1][0], 32'hA000_0008);
        chk("t4_rd_beat3", rdat[1][3], 32'hA000_000B);
        rd_burst(0, 32'h10, 8'd3, 8'h32);
        chk("t4_wr_landed_beat1", rdat[0][1], 32'h2222_2222);
        chk("t4_wr_landed_beat3", rdat[0][3], 32'h4444_4444);

        // Early W data from master 1
        wr_dat[1][0] = 32'hDEAD_BEEF; wr_dat[1][1] = 32'hCAFE_F00D;
        wr_burst(1, 32'h30, 8'd1, 8'h40, 4'hF, 1);
        chk("t5_no_wready_before_aw", 32'(w_early[1]), 0);
        rd_burst(1, 32'h30, 8'd1, 8'h41);
        chk("t5_rd_beat0", rdat[1][0], 32'hDEAD_BEEF);
        chk("t5_rd_beat1", rdat[1][1], 32'hCAFE_F00D);

        // Reset in the middle of a 3-beat read by master 0
        s_mosi[0].data.ar = '{id: 8'h50, addr: 32'h20, len: 8'd2, size: 3'd2, burst: 2'd1};
        s_mosi[0].ar_valid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_miso[0].ar_ready && n < BOUND);
        chk("t6_ar_wait_in_bound", 32'(n < BOUND), 1);
        @(posedge clk); #1;
        s_mosi[0].ar_valid = 0;
        s_mosi[0].r_ready  = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_miso[0].r_valid && n < BOUND);
        chk("t6_r_wait_in_bound", 32'(n < BOUND), 1);
        @(posedge clk); #1;
        chk("t6_rd_busy_mid_burst", 32'(rd_busy), 1);
        rst_n = 0;
        #1;
        chk("t6_reset_any_valid_ready", 32'(any_vr()), 0);
        chk("t6_reset_rd_busy", 32'(rd_busy), 0);
        chk("t6_reset_wr_busy", 32'(wr_busy), 0);
        s_mosi[0].r_ready = 0;
        @(posedge clk); #1;
        rst_n = 1;
        fork
            rd_burst(1, 32'h20, 8'd2, 8'h51);
            begin
                @(posedge clk); @(negedge clk);
                chk("t6_post_rst_rd_busy", 32'(rd_busy), 1);
                chk("t6_post_rst_rd_grant", 32'(rd_grant), 1);
                chk("t6_post_rst_arready", 32'(s_miso[1].ar_ready), 1);
            end
        join
        chk("t6_post_rst_beat0", rdat[1][0], 32'hA000_0008);
        chk("t6_post_rst_beat2", rdat[1][2], 32'hA000_000A);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_ram_arbiter.md
Name: axi_ram_arbiter

Overview:
- Shares one axi_ram slave port between NUM_MASTERS AXI masters, for example a test DMA and a NoC router local port.
- Write path and read path each have an independent round-robin arbiter. A grant is held for one whole transaction: AW, all W beats, then B for writes; AR, then all R beats to RLAST for reads.
- IDs pass through unchanged. Each path allows only one outstanding transaction, so no ID remapping is needed.

Parameters:
- NUM_MASTERS, 2, number of upstream masters (2..8).
- GRANT_W, $clog2(NUM_MASTERS), width of grant index signals.

Ports:
- clk_i  input  1  single clock.
- rst_n_i  input  1  asynchronous active-low reset.
- s_mosi_i  input  axi_mosi_t[NUM_MASTERS]  upstream master requests.
- s_miso_o  output  axi_miso_t[NUM_MASTERS]  upstream master responses.
- m_mosi_o  output  axi_mosi_t  to axi_ram in_mosi_i.
- m_miso_i  input  axi_miso_t  from axi_ram in_miso_o.
- wr_grant_o  output  GRANT_W  index of the master owning the write path.
- rd_grant_o  output  GRANT_W  index of the master owning the read path.
- wr_busy_o  output  1  write path is not in W_IDLE.
- rd_busy_o  output  1  read path is not in R_IDLE.

Behaviour:
- Reset (asynchronous, rst_n_i=0):
  - Both FSMs go to their IDLE state.
  - Round-robin pointers and grant registers are set to 0.
  - All VALID/READY outputs are 0 on both sides; busy outputs are 0.
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE: if any s_mosi_i[k].AWVALID is set, pick the first requester scanning upward from wr_ptr (wrapping at NUM_MASTERS-1). Register it into wr_grant, then go to W_ADDR. Outputs stay gated in this cycle.
  - W_ADDR: route data.aw and AWVALID of the granted master to m_mosi_o, and AWREADY back to it. On AWVALID&&AWREADY, go to W_DATA.
  - W_DATA: route data.w, WVALID and WREADY. On WVALID&&WREADY&&WLAST, go to W_RESP.
  - W_RESP: route data.b, BVALID and BREADY. On BVALID&&BREADY, set wr_ptr = wr_grant+1 (mod NUM_MASTERS) and go to W_IDLE.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - Arbitration is the same as the write path, using ARVALID and rd_ptr.
  - R_ADDR: route AR. On handshake, go to R_DATA.
  - R_DATA: route R. On RVALID&&RREADY&&RLAST, update rd_ptr and go to R_IDLE.
- Routing rules:
  - m_mosi_o channel fields come from the granted master. When a channel is not active, its VALID/READY on m_mosi_o is 0 and its data fields are 0.
  - m_miso_i data fields (b, r) are broadcast to every s_miso_o.
  - VALID/READY toward a master are 0 unless that master holds the grant and the channel is active in the current state.
  - Routing is purely combinational in the active states; no added pipeline latency per beat.
- Latency: AWREADY/ARREADY can reach a master no earlier than 1 cycle after its request is sampled in IDLE (the grant-register cycle).
- W beats arriving before the AW handshake are stalled (WREADY=0 until W_DATA).
- Write and read paths are fully independent. They may grant different masters, or the same master, concurrently.
- If the granted master drops AWVALID/ARVALID before its handshake (an AXI violation), the FSM holds its state and does not re-arbitrate.
- Multiple simultaneous requests: only the round-robin winner is granted. Losers keep VALID asserted and see READY=0 until served.
- A master that requests back-to-back while others are waiting is served again only after every other pending requester has been served.
- Asynchronous reset during a burst aborts it immediately. No B or R is forwarded afterwards, and the slave is expected to be reset by the same rst_n_i.
- wr_grant_o and rd_grant_o show the registered grant; they are meaningful only while the matching busy output is 1.

Test Plan:
- Single write, then read, from master 0:
  - Write AWADDR=1, AWLEN=2, AWSIZE=2, AWBURST=1, data {01234567, 89ABCDEF, FFFFFFFF}, strobes {F, F, 9}.
  - Read back the same burst; expect 01234567, 89ABCDEF, FFxxxxFF.
  - wr_busy_o must return to 0 after the B handshake.
- Simultaneous AWVALID from masters 0 and 1 in the same cycle:
  - Master 0 is served first. Master 1 sees AWREADY=0 until master 0's B handshake, then is served.
  - wr_grant_o sequence is 0 then 1.
- Round-robin fairness: master 0 issues 3 back-to-back single-beat writes while master 1 has one write pending.
  - Grant order must be 0,1,0,0. No master is granted twice in a row while the other is waiting.
- Concurrent paths: master 0 writes a 4-beat burst to addr 0x10 while master 1 reads a 4-beat burst from addr 0x20.
  - Both progress in overlapping cycles.
  - Master 1 never sees BVALID; master 0 never sees RVALID.
- Early W data: master 1 asserts WVALID 2 cycles before AWVALID.
  - WREADY stays 0 until the AW handshake completes, and the data lands correctly.
- Reset mid-burst: assert rst_n_i=0 after beat 1 of a 3-beat read.
  - All VALID/READY outputs go to 0 immediately, and the busy outputs read 0.
  - After reset is released, a new read from master 1 is granted in 1 cycle.
